// File: rtl/arm_pkg.sv
// Shared ARM pipeline types and constants.
// Used by the IF stage and the ID stage.
package arm_pkg;

   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;
   localparam int CNT_W   = 32;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'hD503201F;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic               valid;
   } if_id_t;

   typedef enum logic [1:0] {
      SEL_SEQ    = 2'd0,
      SEL_STALL  = 2'd1,
      SEL_BRANCH = 2'd2
   } pc_sel_e;

endpackage

// File: rtl/instr_fetch_stage_sat_counter.sv
// Saturating event counter.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   // count up once per cycle until all-ones
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: PC, next-PC select, IF/ID register
// and fetch/stall/flush performance counters.
module instr_fetch_stage #(
   parameter int               PC_W      = arm_pkg::PC_W,
   parameter int               INSTR_W   = arm_pkg::INSTR_W,
   parameter logic [PC_W-1:0]  RESET_PC  = PC_W'(arm_pkg::RESET_PC),
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(arm_pkg::NOP_INSTR),
   parameter int               CNT_W     = arm_pkg::CNT_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               stall_ID,
   input  logic               branch_MEM,
   input  logic [PC_W-1:0]    branch_pc_MEM,
   input  logic [INSTR_W-1:0] instr_rom,
   output logic [PC_W-1:0]    pc_IF,
   output logic [INSTR_W-1:0] instr_ID,
   output logic [PC_W-1:0]    pc_ID,
   output logic               valid_ID,
   output logic [CNT_W-1:0]   fetch_count,
   output logic [CNT_W-1:0]   stall_count,
   output logic [CNT_W-1:0]   flush_count
);

   import arm_pkg::*;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic               valid;
   } if_id_w_t;

   pc_sel_e          sel;
   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  pc_d;
   if_id_w_t         if_id_q;
   if_id_w_t         if_id_d;

   // redirect beats stall so a taken branch is never lost
   always_comb begin
      sel = SEL_SEQ;
      if (branch_MEM) begin
         sel = SEL_BRANCH;
      end else if (stall_ID) begin
         sel = SEL_STALL;
      end
   end

   // next PC and next IF/ID contents
   always_comb begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
      unique case (sel)
         SEL_BRANCH: begin
            pc_d          = branch_pc_MEM;
            if_id_d.instr = NOP_INSTR;
            if_id_d.valid = 1'b0;
         end
         SEL_STALL: begin
            pc_d    = pc_q;
            if_id_d = if_id_q;
         end
         default: begin
            pc_d          = pc_q + PC_W'(1);
            if_id_d.instr = instr_rom;
            if_id_d.pc    = pc_q;
            if_id_d.valid = 1'b1;
         end
      endcase
   end

   // PC register
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // IF/ID pipeline register; reset injects a bubble
   always_ff @(posedge clock) begin
      if (reset) begin
         if_id_q.instr <= NOP_INSTR;
         if_id_q.pc    <= '0;
         if_id_q.valid <= 1'b0;
      end else begin
         if_id_q <= if_id_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (sel == SEL_SEQ),
      .count (fetch_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (sel == SEL_STALL),
      .count (stall_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (sel == SEL_BRANCH),
      .count (flush_count)
   );

   assign pc_IF    = pc_q;
   assign instr_ID = if_id_q.instr;
   assign pc_ID    = if_id_q.pc;
   assign valid_ID = if_id_q.valid;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios
// plus randomized traffic against a reference model.
module tb_instr_fetch_stage;

   localparam logic [31:0] NOP  = 32'hD503201F;
   localparam longint      CMAX = 64'h0000_0000_FFFF_FFFF;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // 32-bit instance
   logic        reset_a, stall_a, branch_a;
   logic [31:0] tgt_a, rom_a, pc_a, instr_a, pcid_a;
   logic        valid_a;
   logic [31:0] fc_a, sc_a, flc_a;

   assign rom_a = pc_a + 32'd100;

   instr_fetch_stage u_dut_a (
      .clock         (clock),
      .reset         (reset_a),
      .stall_ID      (stall_a),
      .branch_MEM    (branch_a),
      .branch_pc_MEM (tgt_a),
      .instr_rom     (rom_a),
      .pc_IF         (pc_a),
      .instr_ID      (instr_a),
      .pc_ID         (pcid_a),
      .valid_ID      (valid_a),
      .fetch_count   (fc_a),
      .stall_count   (sc_a),
      .flush_count   (flc_a)
   );

   // narrow instance for wrap and saturation
   logic        reset_b, stall_b, branch_b;
   logic [3:0]  tgt_b, pc_b, pcid_b;
   logic [31:0] rom_b, instr_b;
   logic        valid_b;
   logic [3:0]  fc_b, sc_b, flc_b;

   assign rom_b = {28'd0, pc_b} + 32'd100;

   instr_fetch_stage #(
      .PC_W    (4),
      .INSTR_W (32),
      .CNT_W   (4)
   ) u_dut_b (
      .clock         (clock),
      .reset         (reset_b),
      .stall_ID      (stall_b),
      .branch_MEM    (branch_b),
      .branch_pc_MEM (tgt_b),
      .instr_rom     (rom_b),
      .pc_IF         (pc_b),
      .instr_ID      (instr_b),
      .pc_ID         (pcid_b),
      .valid_ID      (valid_b),
      .fetch_count   (fc_b),
      .stall_count   (sc_b),
      .flush_count   (flc_b)
   );

   // reference model of DUT A
   logic [31:0] m_pc, m_instr, m_pcid;
   logic        m_valid;
   longint      m_fc, m_sc, m_flc;

   task automatic model_step();
      if (reset_a) begin
         m_pc = 32'd0; m_instr = NOP; m_pcid = 32'd0; m_valid = 1'b0;
         m_fc = 0; m_sc = 0; m_flc = 0;
      end else if (branch_a) begin
         m_pc = tgt_a; m_instr = NOP; m_valid = 1'b0;
         if (m_flc < CMAX) m_flc++;
      end else if (stall_a) begin
         if (m_sc < CMAX) m_sc++;
      end else begin
         m_instr = m_pc + 32'd100; m_pcid = m_pc; m_valid = 1'b1;
         m_pc = m_pc + 32'd1;
         if (m_fc < CMAX) m_fc++;
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_a = 1'b1; stall_a = 1'b0; branch_a = 1'b0; tgt_a = '0;
      reset_b = 1'b1; stall_b = 1'b0; branch_b = 1'b0; tgt_b = '0;
      repeat (3) cyc();
      total++;
      if (pc_a !== 32'd0 || instr_a !== NOP || pcid_a !== 32'd0 || valid_a !== 1'b0) begin
         bad++;
         $display("FAIL reset_if: pc=%0d instr=%h pc_ID=%0d valid=%b want 0 %h 0 0",
                  pc_a, instr_a, pcid_a, valid_a, NOP);
      end
      total++;
      if (fc_a !== 0 || sc_a !== 0 || flc_a !== 0) begin
         bad++;
         $display("FAIL reset_cnt: %0d %0d %0d want 0 0 0", fc_a, sc_a, flc_a);
      end
   endtask

   task automatic test_sequential();
      reset_a = 1'b0;
      cyc();
      total++;
      if (pc_a !== 32'd1 || instr_a !== 32'd100 || pcid_a !== 32'd0 || valid_a !== 1'b1) begin
         bad++;
         $display("FAIL seq_edge1: pc=%0d instr=%0d pc_ID=%0d valid=%b want 1 100 0 1",
                  pc_a, instr_a, pcid_a, valid_a);
      end
      cyc();
      total++;
      if (instr_a !== 32'd101 || pcid_a !== 32'd1 || fc_a !== 32'd2) begin
         bad++;
         $display("FAIL seq_edge2: instr=%0d pc_ID=%0d fetch=%0d want 101 1 2",
                  instr_a, pcid_a, fc_a);
      end
   endtask

   task automatic test_stall();
      repeat (3) cyc();
      total++;
      if (pc_a !== 32'd5) begin
         bad++;
         $display("FAIL stall_setup: pc=%0d want 5", pc_a);
      end
      stall_a = 1'b1;
      repeat (3) cyc();
      stall_a = 1'b0;
      total++;
      if (pc_a !== 32'd5 || instr_a !== 32'd104 || pcid_a !== 32'd4 || sc_a !== 32'd3) begin
         bad++;
         $display("FAIL stall_hold: pc=%0d instr=%0d pc_ID=%0d stalls=%0d want 5 104 4 3",
                  pc_a, instr_a, pcid_a, sc_a);
      end
      cyc();
      total++;
      if (pc_a !== 32'd6 || pcid_a !== 32'd5 || valid_a !== 1'b1) begin
         bad++;
         $display("FAIL stall_release: pc=%0d pc_ID=%0d valid=%b want 6 5 1",
                  pc_a, pcid_a, valid_a);
      end
   endtask

   task automatic test_branch();
      repeat (3) cyc();
      branch_a = 1'b1; tgt_a = 32'd40;
      cyc();
      branch_a = 1'b0;
      total++;
      if (pc_a !== 32'd40 || valid_a !== 1'b0 || instr_a !== NOP || pcid_a !== 32'd8
          || flc_a !== 32'd1) begin
         bad++;
         $display("FAIL branch_redirect: pc=%0d valid=%b instr=%h pc_ID=%0d flush=%0d want 40 0 %h 8 1",
                  pc_a, valid_a, instr_a, pcid_a, flc_a, NOP);
      end
      cyc();
      total++;
      if (instr_a !== 32'd140 || pcid_a !== 32'd40 || valid_a !== 1'b1) begin
         bad++;
         $display("FAIL branch_target: instr=%0d pc_ID=%0d valid=%b want 140 40 1",
                  instr_a, pcid_a, valid_a);
      end
   endtask

   task automatic test_branch_stall();
      logic [31:0] sc0;
      sc0 = sc_a;
      branch_a = 1'b1; stall_a = 1'b1; tgt_a = 32'd12;
      cyc();
      branch_a = 1'b0; stall_a = 1'b0;
      total++;
      if (pc_a !== 32'd12 || valid_a !== 1'b0 || sc_a !== sc0 || flc_a !== 32'd2) begin
         bad++;
         $display("FAIL branch_stall: pc=%0d valid=%b stalls=%0d flush=%0d want 12 0 %0d 2",
                  pc_a, valid_a, sc_a, flc_a, sc0);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         branch_a = 1'b1;
         tgt_a = 32'd200 + 32'(i * 17);
         cyc();
         total++;
         if (pc_a !== tgt_a || valid_a !== 1'b0 || instr_a !== NOP) begin
            bad++;
            $display("FAIL b2b_%0d: pc=%0d valid=%b instr=%h want %0d 0 %h",
                     i, pc_a, valid_a, instr_a, tgt_a, NOP);
         end
      end
      branch_a = 1'b0;
      cyc();
      total++;
      if (instr_a !== 32'd334 || pcid_a !== 32'd234 || valid_a !== 1'b1) begin
         bad++;
         $display("FAIL b2b_resume: instr=%0d pc_ID=%0d valid=%b want 334 234 1",
                  instr_a, pcid_a, valid_a);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         stall_a  = ($urandom_range(0, 3) == 0);
         branch_a = ($urandom_range(0, 7) == 0);
         tgt_a    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                                : $urandom;
         cyc();
         total++;
         if (pc_a !== m_pc || instr_a !== m_instr || pcid_a !== m_pcid || valid_a !== m_valid
             || fc_a !== m_fc[31:0] || sc_a !== m_sc[31:0] || flc_a !== m_flc[31:0]) begin
            bad++;
            $display("FAIL random_%0d: pc=%h/%h instr=%h/%h pc_ID=%h/%h v=%b/%b cnt=%0d,%0d,%0d/%0d,%0d,%0d",
                     i, pc_a, m_pc, instr_a, m_instr, pcid_a, m_pcid, valid_a, m_valid,
                     fc_a, sc_a, flc_a, m_fc, m_sc, m_flc);
         end
      end
      stall_a = 1'b0; branch_a = 1'b0;
   endtask

   task automatic test_reset_mid();
      cyc();
      stall_a = 1'b1;
      total++;
      if (valid_a !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_setup: valid=%b want 1", valid_a);
      end
      reset_a = 1'b1;
      cyc();
      total++;
      if (pc_a !== 32'd0 || valid_a !== 1'b0 || instr_a !== NOP || pcid_a !== 32'd0
          || fc_a !== 0 || sc_a !== 0 || flc_a !== 0) begin
         bad++;
         $display("FAIL reset_mid: pc=%0d valid=%b instr=%h pc_ID=%0d cnt=%0d,%0d,%0d want 0 0 %h 0 0,0,0",
                  pc_a, valid_a, instr_a, pcid_a, fc_a, sc_a, flc_a, NOP);
      end
      reset_a = 1'b0; stall_a = 1'b0;
   endtask

   task automatic test_wrap();
      reset_b = 1'b1;
      @(posedge clock); #1;
      reset_b = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         @(posedge clock); #1;
         if (k == 16) begin
            total++;
            if (pc_b !== 4'd0 || pcid_b !== 4'd15 || instr_b !== 32'd115) begin
               bad++;
               $display("FAIL wrap_edge: pc=%0d pc_ID=%0d instr=%0d want 0 15 115",
                        pc_b, pcid_b, instr_b);
            end
         end
      end
      total++;
      if (pc_b !== 4'd1 || fc_b !== 4'd15 || sc_b !== 4'd0 || flc_b !== 4'd0) begin
         bad++;
         $display("FAIL wrap_sat: pc=%0d fetch=%0d stalls=%0d flush=%0d want 1 15 0 0",
                  pc_b, fc_b, sc_b, flc_b);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_branch_stall();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
